// File: rtl/hazard_control_if.sv
// Pipeline hazard control bus between the hazard unit and the pipeline registers.
//   master : pipeline side, drives IF/ID and ID/EX fields plus MEM branch resolution
//   slave  : hazard unit, drives PC/IF/ID load enables, bubble/flush controls, debug state
interface hazard_control_if;
    localparam int unsigned REG_W   = 5;
    localparam int unsigned STATE_W = 2;

    logic               ifid_valid;
    logic [REG_W-1:0]   ifid_read_register1;
    logic [REG_W-1:0]   ifid_read_register2;
    logic               ifid_uses_reg2;
    logic               idex_MemRead;
    logic [REG_W-1:0]   idex_write_register;
    logic               idex_RegWrite;
    logic               branch_taken;

    logic               PC_write;
    logic               IFID_write;
    logic               IDEX_bubble;
    logic               IFID_flush;
    logic               IDEX_flush;
    logic               EXMEM_flush;
    logic [STATE_W-1:0] hz_state;

    modport master (
        output ifid_valid, ifid_read_register1, ifid_read_register2, ifid_uses_reg2,
        output idex_MemRead, idex_write_register, idex_RegWrite, branch_taken,
        input  PC_write, IFID_write, IDEX_bubble, IFID_flush, IDEX_flush, EXMEM_flush,
        input  hz_state
    );

    modport slave (
        input  ifid_valid, ifid_read_register1, ifid_read_register2, ifid_uses_reg2,
        input  idex_MemRead, idex_write_register, idex_RegWrite, branch_taken,
        output PC_write, IFID_write, IDEX_bubble, IFID_flush, IDEX_flush, EXMEM_flush,
        output hz_state
    );
endinterface

// File: rtl/hazard_control.sv
// Pipeline hazard controller: load-use stall and MEM-resolved taken-branch flush.
// Ports:
//   clock       : rising-edge clock
//   reset       : asynchronous active-low reset
//   hz          : hazard_control_if.slave (pipeline fields in, stall/bubble/flush out)
//   stall_count : RUN->STALL transitions, saturating  (HAZARD_STATS_EN only)
//   flush_count : transitions into FLUSH, saturating   (HAZARD_STATS_EN only)
// Control outputs are combinational from the state and the current inputs.
// Optional feature macro: HAZARD_STATS_EN (adds the two event counters).
module hazard_control #(
    parameter int unsigned CNT_W    = 32,
    parameter int unsigned ZERO_REG = 31
) (
    input  logic             clock,
    input  logic             reset,
`ifdef HAZARD_STATS_EN
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count,
`endif
    hazard_control_if.slave  hz
);
    localparam int unsigned REG_W = 5;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   load_use;
    logic   src_match;

    // Destination of an in-flight load matches a source read by the IF/ID instruction.
    assign src_match = (hz.idex_write_register == hz.ifid_read_register1) ||
                       (hz.ifid_uses_reg2 && (hz.idex_write_register == hz.ifid_read_register2));

    assign load_use = hz.idex_MemRead && hz.idex_RegWrite && hz.ifid_valid &&
                      (hz.idex_write_register != REG_W'(ZERO_REG)) && src_match;

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= RUN;
        else        state <= state_nxt;
    end

    // Next state and control outputs; FLUSH ignores everything since MEM and IF/ID hold bubbles.
    always_comb begin
        state_nxt      = RUN;
        hz.PC_write    = 1'b1;
        hz.IFID_write  = 1'b1;
        hz.IDEX_bubble = 1'b0;
        hz.IFID_flush  = 1'b0;
        hz.IDEX_flush  = 1'b0;
        hz.EXMEM_flush = 1'b0;
        case (state)
            RUN, STALL: begin
                if (hz.branch_taken) begin
                    hz.IFID_flush  = 1'b1;
                    hz.IDEX_flush  = 1'b1;
                    hz.EXMEM_flush = 1'b1;
                    state_nxt      = FLUSH;
                end else if ((state == RUN) && load_use) begin
                    // Load-use is suppressed in STALL so the stall lasts exactly one cycle.
                    hz.PC_write    = 1'b0;
                    hz.IFID_write  = 1'b0;
                    hz.IDEX_bubble = 1'b1;
                    state_nxt      = STALL;
                end
            end
            FLUSH:   state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    assign hz.hz_state = state;

`ifdef HAZARD_STATS_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Saturating event counters.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if ((state == RUN) && (state_nxt == STALL) && (stall_count != CNT_MAX))
                stall_count <= stall_count + CNT_W'(1);
            if ((state_nxt == FLUSH) && (flush_count != CNT_MAX))
                flush_count <= flush_count + CNT_W'(1);
        end
    end
`else
    logic [CNT_W-1:0] unused_cnt_w;
    assign unused_cnt_w = '0;
`endif
endmodule

// File: tb/tb_hazard_control.sv
// Self-checking bench for hazard_control: directed scenarios plus randomized
// stimulus checked against a rule-level reference model.
module tb_hazard_control;
`ifdef HAZARD_STATS_EN
    localparam int unsigned TB_CNT_W = 2;
    localparam int CMAX = (1 << TB_CNT_W) - 1;
`else
    localparam int unsigned TB_CNT_W = 32;
`endif

    typedef struct packed {
        logic       v;
        logic [4:0] r1;
        logic [4:0] r2;
        logic       u2;
        logic       mr;
        logic [4:0] wr;
        logic       rw;
        logic       br;
    } stim_t;

    // Observed/expected vector: {hz_state, PC_write, IFID_write, IDEX_bubble, IFID_flush, IDEX_flush, EXMEM_flush}
    localparam logic [7:0] E_RUN_PASS   = 8'b00_110000;
    localparam logic [7:0] E_STALL      = 8'b00_001000;
    localparam logic [7:0] E_STALL_PASS = 8'b01_110000;
    localparam logic [7:0] E_FLUSH_PASS = 8'b10_110000;
    localparam logic [7:0] E_RUN_FLUSH  = 8'b00_110111;
    localparam logic [7:0] E_STL_FLUSH  = 8'b01_110111;

    logic clock;
    logic reset;
`ifdef HAZARD_STATS_EN
    logic [TB_CNT_W-1:0] stall_count;
    logic [TB_CNT_W-1:0] flush_count;
    int m_scnt;
    int m_fcnt;
`endif

    hazard_control_if bus ();

    hazard_control #(.CNT_W(TB_CNT_W), .ZERO_REG(31)) dut (
        .clock      (clock),
        .reset      (reset),
`ifdef HAZARD_STATS_EN
        .stall_count(stall_count),
        .flush_count(flush_count),
`endif
        .hz         (bus)
    );

    int    total;
    int    bad;
    int    m_mode;  // 0 running, 1 just stalled, 2 just flushed
    int    m_next;
    stim_t cur;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic stim_t mk(input logic v, input int r1, input int r2, input logic u2,
                                 input logic mr, input int wr, input logic rw, input logic br);
        stim_t s;
        s.v = v; s.r1 = 5'(r1); s.r2 = 5'(r2); s.u2 = u2;
        s.mr = mr; s.wr = 5'(wr); s.rw = rw; s.br = br;
        return s;
    endfunction

    function automatic stim_t idle();
        return mk(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    endfunction

    function automatic int rnd_reg();
        int k;
        k = int'($urandom_range(0, 4));
        return (k == 4) ? 31 : k;
    endfunction

    function automatic stim_t rnd_stim();
        stim_t s;
        s.v  = 1'($urandom_range(0, 3) != 0);
        s.r1 = 5'(rnd_reg());
        s.r2 = 5'(rnd_reg());
        s.u2 = 1'($urandom);
        s.mr = 1'($urandom_range(0, 3) != 0);
        s.wr = 5'(rnd_reg());
        s.rw = 1'($urandom_range(0, 3) != 0);
        s.br = 1'($urandom_range(0, 5) == 0);
        return s;
    endfunction

    // Reference model: expected outputs for the current mode and inputs; also records the next mode.
    function automatic logic [7:0] calc(input int mode, input stim_t s);
        bit         lu;
        logic [1:0] st;
        lu = s.mr && s.rw && (s.wr != 5'd31) && s.v &&
             ((s.wr == s.r1) || (s.u2 && (s.wr == s.r2)));
        st = 2'(mode);
        if (mode == 2) begin
            m_next = 0;
            return {st, 6'b110000};
        end
        if (s.br) begin
            m_next = 2;
            return {st, 6'b110111};
        end
        if (lu && (mode == 0)) begin
            m_next = 1;
            return {st, 6'b001000};
        end
        m_next = 0;
        return {st, 6'b110000};
    endfunction

    function automatic logic [7:0] obs();
        return {bus.hz_state, bus.PC_write, bus.IFID_write, bus.IDEX_bubble,
                bus.IFID_flush, bus.IDEX_flush, bus.EXMEM_flush};
    endfunction

    task automatic apply(input stim_t s);
        cur = s;
        bus.ifid_valid          = s.v;
        bus.ifid_read_register1 = s.r1;
        bus.ifid_read_register2 = s.r2;
        bus.ifid_uses_reg2      = s.u2;
        bus.idex_MemRead        = s.mr;
        bus.idex_write_register = s.wr;
        bus.idex_RegWrite       = s.rw;
        bus.branch_taken        = s.br;
    endtask

    // Advance one clock, keeping the reference model in step; returns at the next falling edge.
    task automatic tick();
        logic [7:0] unused_e;
        unused_e = calc(m_mode, cur);
        @(posedge clock);
        if (reset) begin
`ifdef HAZARD_STATS_EN
            if ((m_mode == 0) && (m_next == 1) && (m_scnt < CMAX)) m_scnt++;
            if ((m_next == 2) && (m_fcnt < CMAX)) m_fcnt++;
`endif
            m_mode = m_next;
        end else begin
            m_mode = 0;
`ifdef HAZARD_STATS_EN
            m_scnt = 0;
            m_fcnt = 0;
`endif
        end
        @(negedge clock);
    endtask

    task automatic test_reset();
        logic [7:0] e;
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            apply(rnd_stim());
            #1;
            e = calc(0, cur);
            total++;
            if (obs() !== e) begin
                bad++;
                $display("FAIL reset_rand[%0d] got=%b want=%b", i, obs(), e);
            end
            tick();
        end
        apply(idle());
        #1;
        total++;
        if (obs() !== E_RUN_PASS) begin
            bad++;
            $display("FAIL reset_idle got=%b want=%b", obs(), E_RUN_PASS);
        end
        reset = 1'b1;
        #1;
        total++;
        if (obs() !== E_RUN_PASS) begin
            bad++;
            $display("FAIL reset_release got=%b want=%b", obs(), E_RUN_PASS);
        end
`ifdef HAZARD_STATS_EN
        total++;
        if ((stall_count !== '0) || (flush_count !== '0)) begin
            bad++;
            $display("FAIL reset_counters got=%0d/%0d want=0/0", stall_count, flush_count);
        end
`endif
        tick();
    endtask

    task automatic run_directed(input string name, input stim_t st[$], input logic [7:0] ex[$]);
        for (int i = 0; i < st.size(); i++) begin
            apply(st[i]);
            #1;
            total++;
            if (obs() !== ex[i]) begin
                bad++;
                $display("FAIL %s[%0d] got=%b want=%b", name, i, obs(), ex[i]);
            end
            tick();
        end
    endtask

    task automatic test_load_use();
        stim_t      st[$];
        logic [7:0] ex[$];
        stim_t      lu;
        lu = mk(1'b1, 5, 0, 1'b0, 1'b1, 5, 1'b1, 1'b0);
        st = '{lu, lu, idle()};
        ex = '{E_STALL, E_STALL_PASS, E_RUN_PASS};
        run_directed("load_use", st, ex);
    endtask

    task automatic test_zero_reg();
        stim_t      st[$];
        logic [7:0] ex[$];
        st = '{mk(1'b1, 31, 31, 1'b1, 1'b1, 31, 1'b1, 1'b0),
               mk(1'b1, 0, 5, 1'b0, 1'b1, 5, 1'b1, 1'b0),
               mk(1'b1, 21, 21, 1'b1, 1'b1, 5, 1'b1, 1'b0),
               mk(1'b0, 5, 5, 1'b1, 1'b1, 5, 1'b1, 1'b0),
               mk(1'b1, 0, 5, 1'b1, 1'b1, 5, 1'b1, 1'b0),
               idle(), idle()};
        ex = '{E_RUN_PASS, E_RUN_PASS, E_RUN_PASS, E_RUN_PASS,
               E_STALL, E_STALL_PASS, E_RUN_PASS};
        run_directed("reg_match", st, ex);
    endtask

    task automatic test_branch();
        stim_t      st[$];
        logic [7:0] ex[$];
        stim_t      br;
        br = mk(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b1);
        st = '{br, br, idle()};
        ex = '{E_RUN_FLUSH, E_FLUSH_PASS, E_RUN_PASS};
        run_directed("branch", st, ex);
    endtask

    task automatic test_priority();
        stim_t      st[$];
        logic [7:0] ex[$];
        stim_t      lu;
        stim_t      lubr;
        lu   = mk(1'b1, 5, 0, 1'b0, 1'b1, 5, 1'b1, 1'b0);
        lubr = mk(1'b1, 5, 0, 1'b0, 1'b1, 5, 1'b1, 1'b1);
        st = '{lubr, lu, lu, lubr, idle(), idle()};
        ex = '{E_RUN_FLUSH, E_FLUSH_PASS, E_STALL, E_STL_FLUSH, E_FLUSH_PASS, E_RUN_PASS};
        run_directed("priority", st, ex);
    endtask

    task automatic test_random();
        logic [7:0] e;
        for (int i = 0; i < 400; i++) begin
            apply(rnd_stim());
            #1;
            e = calc(m_mode, cur);
            total++;
            if (obs() !== e) begin
                bad++;
                $display("FAIL random[%0d] got=%b want=%b", i, obs(), e);
            end
`ifdef HAZARD_STATS_EN
            total++;
            if ((int'(stall_count) != m_scnt) || (int'(flush_count) != m_fcnt)) begin
                bad++;
                $display("FAIL random_cnt[%0d] got=%0d/%0d want=%0d/%0d",
                         i, stall_count, flush_count, m_scnt, m_fcnt);
            end
`endif
            tick();
        end
        apply(idle());
        tick();
        tick();
    endtask

    task automatic test_reset_mid();
        apply(mk(1'b1, 7, 0, 1'b0, 1'b1, 7, 1'b1, 1'b0));
        tick();
        apply(idle());
        #1;
        total++;
        if (obs() !== E_STALL_PASS) begin
            bad++;
            $display("FAIL mid_stall_pre got=%b want=%b", obs(), E_STALL_PASS);
        end
        #1 reset = 1'b0;
        #1;
        total++;
        if (obs() !== E_RUN_PASS) begin
            bad++;
            $display("FAIL mid_stall_reset got=%b want=%b", obs(), E_RUN_PASS);
        end
`ifdef HAZARD_STATS_EN
        total++;
        if ((stall_count !== '0) || (flush_count !== '0)) begin
            bad++;
            $display("FAIL mid_stall_cnt got=%0d/%0d want=0/0", stall_count, flush_count);
        end
`endif
        tick();
        reset = 1'b1;
        apply(mk(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b1));
        tick();
        apply(idle());
        #1;
        total++;
        if (obs() !== E_FLUSH_PASS) begin
            bad++;
            $display("FAIL mid_flush_pre got=%b want=%b", obs(), E_FLUSH_PASS);
        end
        #1 reset = 1'b0;
        #1;
        total++;
        if (obs() !== E_RUN_PASS) begin
            bad++;
            $display("FAIL mid_flush_reset got=%b want=%b", obs(), E_RUN_PASS);
        end
        tick();
        reset = 1'b1;
        tick();
    endtask

`ifdef HAZARD_STATS_EN
    task automatic test_stats();
        int    want_s[4];
        stim_t lu;
        want_s = '{1, 2, 3, 3};
        lu = mk(1'b1, 9, 0, 1'b0, 1'b1, 9, 1'b1, 1'b0);
        reset = 1'b0;
        apply(idle());
        tick();
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            apply(lu);
            tick();
            total++;
            if (int'(stall_count) != want_s[k]) begin
                bad++;
                $display("FAIL stall_count[%0d] got=%0d want=%0d", k, stall_count, want_s[k]);
            end
            apply(idle());
            tick();
        end
        apply(mk(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b1));
        tick();
        total++;
        if (int'(flush_count) != 1) begin
            bad++;
            $display("FAIL flush_count got=%0d want=1", flush_count);
        end
        apply(idle());
        tick();
    endtask
`endif

    initial begin
        total  = 0;
        bad    = 0;
        m_mode = 0;
        m_next = 0;
`ifdef HAZARD_STATS_EN
        m_scnt = 0;
        m_fcnt = 0;
`endif
        reset = 1'b0;
        apply(idle());
        @(negedge clock);
        test_reset();
        test_load_use();
        test_zero_reg();
        test_branch();
        test_priority();
        test_reset_mid();
`ifdef HAZARD_STATS_EN
        test_stats();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/hazard_control.md
Name: hazard_control

Overview:
- Pipeline hazard controller. It reads the ID/EX pipeline register outputs together with the IF/ID instruction fields, and drives the stall, bubble and flush controls back into the PC, IF/ID, ID/EX and EX/MEM registers.
- It detects load-use hazards and taken branches resolved in MEM.
- A small FSM guarantees that a load-use stall lasts exactly one cycle and that a flush is not re-triggered by the wrong-path bubbles it creates.

Parameters:
- CNT_W, 32, width of the event counters.
- ZERO_REG, 31, register index that never creates a hazard (XZR).

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- ifid_valid  in  1  IF/ID holds a real instruction.
- ifid_read_register1  in  5  Rn field of the instruction in IF/ID.
- ifid_read_register2  in  5  Rm/Rt field of the instruction in IF/ID.
- ifid_uses_reg2  in  1  instruction in IF/ID reads read_register2.
- idex_MemRead  in  1  MemRead_out of ID/EX.
- idex_write_register  in  5  write_register_out of ID/EX.
- idex_RegWrite  in  1  RegWrite_out of ID/EX.
- branch_taken  in  1  MEM-stage branch resolution: taken (conditional, unconditional or Branchreg).
- PC_write  out  1  PC load enable.
- IFID_write  out  1  IF/ID load enable.
- IDEX_bubble  out  1  force all ID/EX control bits to 0 on the next edge.
- IFID_flush  out  1  clear IF/ID on the next edge.
- IDEX_flush  out  1  clear ID/EX on the next edge.
- EXMEM_flush  out  1  clear EX/MEM on the next edge.
- hz_state  out  2  current FSM state (debug).

Behaviour:
- FSM states: RUN=0, STALL=1, FLUSH=2. State 3 is illegal and returns to RUN on the next edge.
- Reset (reset=0, asynchronous): state=RUN. All outputs take their combinational RUN values for idle inputs:
  - PC_write=1, IFID_write=1.
  - IDEX_bubble=0, IFID_flush=0, IDEX_flush=0, EXMEM_flush=0.
  - hz_state=0.
- load_use is asserted when all of the following hold:
  - idex_MemRead=1 and idex_RegWrite=1;
  - idex_write_register != ZERO_REG;
  - ifid_valid=1;
  - (idex_write_register == ifid_read_register1) or (ifid_uses_reg2=1 and idex_write_register == ifid_read_register2).
- Control outputs are combinational from state and inputs (zero latency). The state register updates on the rising clock edge.
- RUN, branch_taken=1 (priority over load_use):
  - IFID_flush=IDEX_flush=EXMEM_flush=1, PC_write=1, IDEX_bubble=0.
  - Next state FLUSH.
- RUN, load_use=1 and branch_taken=0:
  - PC_write=0, IFID_write=0, IDEX_bubble=1.
  - Next state STALL.
- RUN, neither condition: pass-through values; stay in RUN.
- STALL:
  - load_use detection is suppressed; PC_write=1, IFID_write=1, no bubble.
  - branch_taken=1 is still honoured exactly as in RUN (flush, next state FLUSH).
  - Otherwise next state RUN.
  - The stall is exactly 1 cycle.
- FLUSH:
  - branch_taken and load_use are both ignored, because MEM and IF/ID hold flushed bubbles.
  - Pass-through values; next state RUN.
- Comparisons are full 5-bit equality.
- ZERO_REG as a destination never stalls, regardless of the source fields.
- Reset asserted mid-stall or mid-flush: state immediately returns to RUN and outputs revert to RUN values.

Optional Feature:
- Macro: HAZARD_STATS_EN.
- When defined, two extra outputs are added:
  - stall_count [CNT_W-1:0]: increments on every edge where the RUN to STALL transition occurs.
  - flush_count [CNT_W-1:0]: increments on every edge where a transition into FLUSH occurs.
  - Both counters saturate at all-ones and are cleared to 0 by reset.
- When not defined, these ports and counters do not exist. All other behaviour is identical.

Test Plan:
- Reset=0 with random inputs, then release -> hz_state=0, PC_write=1, IFID_write=1, all flush and bubble outputs 0.
- LDUR X5 in ID/EX (idex_MemRead=1, idex_RegWrite=1, idex_write_register=5) with ifid_read_register1=5 -> one cycle of PC_write=0, IFID_write=0, IDEX_bubble=1. Next cycle pass-through with hz_state=1, then hz_state=0.
- Same load with idex_write_register=31 and ifid_read_register1=31 -> no stall. With ifid_read_register2=5 and ifid_uses_reg2=0 -> no stall; with ifid_uses_reg2=1 -> stall.
- branch_taken=1 in RUN -> IFID_flush=IDEX_flush=EXMEM_flush=1 for one cycle, then hz_state=2. branch_taken held at 1 in the next cycle -> no second flush.
- load_use and branch_taken together in RUN -> flush only, PC_write=1, IDEX_bubble=0, next state FLUSH. branch_taken=1 while in STALL -> flush, next state FLUSH.
- HAZARD_STATS_EN defined, CNT_W=2: four stalls -> stall_count goes 1, 2, 3, 3 (saturated). Reset mid-stall -> counters read 0 and hz_state=0.
